color_stabilizer: RTL and testbench

- Sits directly downstream of the colour-interpretation stage and upstream of Core.
- Samples the raw 2-bit object/station colour codes on a fixed-period tick and debounces each channel. A code must be seen on CONFIRM consecutive ticks before it becomes the stable colour.
- Presents Core with the stable codes, one-cycle change pulses, and an object/station match flag with a rise pulse.

---
 rtl/color_stabilizer.sv | 116 +++++++++++
 tb/tb_color_stabilizer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/color_stabilizer.sv
// Debounces the raw object/station colour codes on a periodic sample tick and
// presents stable codes, change pulses and an object/station match indication.
module color_stabilizer #(
    parameter int SAMPLE_PERIOD = 4000,
    parameter int CNT_W         = 12,
    parameter int CONFIRM       = 3,
    parameter int RUN_W         = 3
) (
    input  logic       clkus,
    input  logic       rst,
    input  logic [1:0] object_color,
    input  logic [1:0] station_color,
    input  logic       hold,
    output logic [1:0] object_stable,
    output logic [1:0] station_stable,
    output logic       object_changed,
    output logic       station_changed,
    output logic       match,
    output logic       match_rise
);

    localparam logic [CNT_W-1:0] LAST_TICK_C = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [RUN_W-1:0] CONFIRM_C   = RUN_W'(CONFIRM);

    // Channel 0 is the object, channel 1 the station.
    logic [CNT_W-1:0] cnt_r;
    logic             tick_s;
    logic [1:0]       sample_s     [2];
    logic [1:0]       cand_r       [2];
    logic [1:0]       cand_nxt_s   [2];
    logic [1:0]       stable_r     [2];
    logic [1:0]       stable_nxt_s [2];
    logic [RUN_W-1:0] run_r        [2];
    logic [RUN_W-1:0] run_nxt_s    [2];
    logic [RUN_W-1:0] new_run_s    [2];
    logic [1:0]       changed_r;
    logic [1:0]       changed_nxt_s;
    logic             match_s;
    logic             match_d_r;
    logic             match_rise_r;

    assign sample_s[0] = object_color;
    assign sample_s[1] = station_color;
    assign tick_s      = (cnt_r == LAST_TICK_C);
    assign match_s     = (stable_r[0] == stable_r[1]) && (stable_r[0] != 2'd0);

    // Per-channel run-length debounce; a held or non-tick cycle only clears the pulse.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            cand_nxt_s[ch]    = cand_r[ch];
            run_nxt_s[ch]     = run_r[ch];
            new_run_s[ch]     = run_r[ch];
            stable_nxt_s[ch]  = stable_r[ch];
            changed_nxt_s[ch] = 1'b0;
            if (tick_s && !hold) begin
                if (sample_s[ch] == cand_r[ch]) begin
                    if (run_r[ch] < CONFIRM_C) begin
                        new_run_s[ch] = run_r[ch] + RUN_W'(1);
                    end else begin
                        new_run_s[ch] = CONFIRM_C;
                    end
                end else begin
                    new_run_s[ch] = RUN_W'(1);
                end
                cand_nxt_s[ch] = sample_s[ch];
                run_nxt_s[ch]  = new_run_s[ch];
                if ((new_run_s[ch] == CONFIRM_C) && (sample_s[ch] != stable_r[ch])) begin
                    stable_nxt_s[ch]  = sample_s[ch];
                    changed_nxt_s[ch] = 1'b1;
                end else begin
                    stable_nxt_s[ch]  = stable_r[ch];
                    changed_nxt_s[ch] = 1'b0;
                end
            end else begin
                changed_nxt_s[ch] = 1'b0;
            end
        end
    end

    // Tick counter, channel state and match edge registers.
    always_ff @(posedge clkus) begin
        if (rst) begin
            cnt_r        <= '0;
            changed_r    <= 2'b00;
            match_d_r    <= 1'b0;
            match_rise_r <= 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                cand_r[ch]   <= 2'd0;
                run_r[ch]    <= '0;
                stable_r[ch] <= 2'd0;
            end
        end else begin
            if (tick_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            changed_r    <= changed_nxt_s;
            match_d_r    <= match_s;
            match_rise_r <= match_s & ~match_d_r;
            for (int ch = 0; ch < 2; ch++) begin
                cand_r[ch]   <= cand_nxt_s[ch];
                run_r[ch]    <= run_nxt_s[ch];
                stable_r[ch] <= stable_nxt_s[ch];
            end
        end
    end

    assign object_stable   = stable_r[0];
    assign station_stable  = stable_r[1];
    assign object_changed  = changed_r[0];
    assign station_changed = changed_r[1];
    assign match           = match_s;
    assign match_rise      = match_rise_r;

endmodule

// File: tb/tb_color_stabilizer.sv
// Directed and randomized bench for color_stabilizer against a sample-history model.
module tb_color_stabilizer;

    localparam int P = 10;
    localparam int C = 3;

    logic       clkus = 1'b0;
    logic       rst;
    logic [1:0] object_color;
    logic [1:0] station_color;
    logic       hold;
    logic [1:0] object_stable;
    logic [1:0] station_stable;
    logic       object_changed;
    logic       station_changed;
    logic       match;
    logic       match_rise;

    color_stabilizer #(
        .SAMPLE_PERIOD(P),
        .CNT_W        (4),
        .CONFIRM      (C),
        .RUN_W        (3)
    ) dut (
        .clkus          (clkus),
        .rst            (rst),
        .object_color   (object_color),
        .station_color  (station_color),
        .hold           (hold),
        .object_stable  (object_stable),
        .station_stable (station_stable),
        .object_changed (object_changed),
        .station_changed(station_changed),
        .match          (match),
        .match_rise     (match_rise)
    );

    always #5 clkus = ~clkus;

    int checks = 0;
    int errors = 0;

    // Reference model: cycles since release, last C accepted samples per channel.
    int         cyc;
    int         hist [2][C];
    int         hcnt [2];
    logic [1:0] m_stable [2];
    logic       m_changed [2];
    logic       m_match_d;
    logic       m_rise;
    int         pulse_cycle;

    function automatic logic model_match();
        return (m_stable[0] == m_stable[1]) && (m_stable[0] != 2'd0);
    endfunction

    task automatic model_edge(input logic [1:0] o, input logic [1:0] s, input logic h, input logic r);
        int smp [2];
        logic all_same;
        logic mm;
        smp[0] = int'(o);
        smp[1] = int'(s);
        if (r) begin
            cyc = 0;
            m_match_d = 1'b0;
            m_rise = 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                hcnt[ch] = 0;
                m_stable[ch] = 2'd0;
                m_changed[ch] = 1'b0;
            end
        end else begin
            mm = model_match();
            m_rise = mm && !m_match_d;
            m_match_d = mm;
            for (int ch = 0; ch < 2; ch++) begin
                m_changed[ch] = 1'b0;
                if ((cyc % P) == P - 1 && !h) begin
                    for (int i = 0; i < C - 1; i++) hist[ch][i] = hist[ch][i+1];
                    hist[ch][C-1] = smp[ch];
                    if (hcnt[ch] < C) hcnt[ch]++;
                    all_same = (hcnt[ch] == C);
                    for (int i = 0; i < C; i++) if (hist[ch][i] != smp[ch]) all_same = 1'b0;
                    if (all_same && smp[ch] != int'(m_stable[ch])) begin
                        m_stable[ch] = 2'(smp[ch]);
                        m_changed[ch] = 1'b1;
                    end
                end
            end
            cyc++;
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic [1:0] o, input logic [1:0] s, input logic h, input logic r);
        object_color  = o;
        station_color = s;
        hold          = h;
        rst           = r;
        @(posedge clkus);
        model_edge(o, s, h, r);
        #1;
        chk("object_stable",   object_stable,         m_stable[0]);
        chk("station_stable",  station_stable,        m_stable[1]);
        chk("object_changed",  {1'b0, object_changed},  {1'b0, m_changed[0]});
        chk("station_changed", {1'b0, station_changed}, {1'b0, m_changed[1]});
        chk("match",           {1'b0, match},           {1'b0, model_match()});
        chk("match_rise",      {1'b0, match_rise},      {1'b0, m_rise});
    endtask

    task automatic run_ticks(input logic [1:0] o, input logic [1:0] s, input logic h, input int n);
        for (int i = 0; i < n * P; i++) step(o, s, h, 1'b0);
    endtask

    initial begin
        logic [1:0] ro;
        logic [1:0] rs;
        object_color = 2'd2; station_color = 2'd2; hold = 1'b0; rst = 1'b1;

        // Reset with inputs at 2: everything zero, no pulses.
        for (int i = 0; i < 3; i++) step(2'd2, 2'd2, 1'b0, 1'b1);
        chk("reset_stable", object_stable, 2'd0);

        // Acceptance: object 1 from release; pulse expected after the edge of the 3rd tick.
        pulse_cycle = -1;
        for (int i = 1; i <= 4 * P; i++) begin
            step(2'd1, 2'd0, 1'b0, 1'b0);
            if (object_changed && pulse_cycle < 0) pulse_cycle = i;
        end
        checks++;
        assert (pulse_cycle == 3 * P) else begin
            errors++;
            $error("FAIL accept_latency observed %0d expected %0d", pulse_cycle, 3 * P);
        end
        chk("accept_value", object_stable, 2'd1);

        // Glitch of two ticks is rejected, three ticks is accepted.
        run_ticks(2'd3, 2'd0, 1'b0, 2);
        run_ticks(2'd1, 2'd0, 1'b0, 2);
        chk("glitch_rejected", object_stable, 2'd1);
        run_ticks(2'd3, 2'd0, 1'b0, 3);
        chk("glitch_accepted", object_stable, 2'd3);

        // Hold: run 2 on candidate 2, hold through 4 ticks of 0, then one tick of 2.
        run_ticks(2'd2, 2'd0, 1'b0, 2);
        run_ticks(2'd0, 2'd0, 1'b1, 4);
        chk("hold_kept", object_stable, 2'd3);
        run_ticks(2'd2, 2'd0, 1'b0, 1);
        chk("hold_release_accept", object_stable, 2'd2);

        // Match: both channels to 1 together, then station drops to 0.
        run_ticks(2'd1, 2'd1, 1'b0, 3);
        chk("match_both", {1'b0, match}, 2'd1);
        run_ticks(2'd1, 2'd0, 1'b0, 3);
        chk("match_fall", {1'b0, match}, 2'd0);

        // Reset on the tick where object 3 would be accepted.
        run_ticks(2'd3, 2'd0, 1'b0, 2);
        for (int i = 0; i < P - 1; i++) step(2'd3, 2'd0, 1'b0, 1'b0);
        step(2'd3, 2'd0, 1'b0, 1'b1);
        chk("midreset_stable", object_stable, 2'd0);
        chk("midreset_pulse", {1'b0, object_changed}, 2'd0);
        run_ticks(2'd3, 2'd3, 1'b0, 3);

        // Randomized: inputs mostly persist per tick period, random hold and rare resets.
        ro = 2'd0; rs = 2'd0;
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 2) == 0) ro = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) rs = 2'($urandom_range(0, 3));
            for (int i = 0; i < P; i++)
                step(ro, rs, ($urandom_range(0, 15) == 0), ($urandom_range(0, 499) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
